// File: rtl/hazard_if.sv
// Pipeline hazard control bundle: pipeline status into the controller,
// stall/flush/bubble controls and performance counters back out.
interface hazard_if;
    logic [31:0] id_instr;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_ready;

    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_stall;
    logic        mem_wb_stall;
    logic        mem_timeout;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;

    // Pipeline side: drives stage status, consumes hazard controls.
    modport master (
        output id_instr, ex_rd, ex_mem_read, branch_taken, dmem_req, dmem_ready,
        input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush,
               ex_mem_stall, mem_wb_stall, mem_timeout, stall_cycles, flush_count
    );

    // Hazard controller side.
    modport slave (
        input  id_instr, ex_rd, ex_mem_read, branch_taken, dmem_req, dmem_ready,
        output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush,
               ex_mem_stall, mem_wb_stall, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage RV32 pipeline: load-use interlock,
// branch flush, memory-wait freeze with timeout, and saturating
// stall/flush performance counters.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_RUN      | pipeline flowing; wait counter held at zero
// ST_MEM_WAIT | a data-memory access is outstanding; wait cycles counted
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic    clk,
    input logic    reset,
    hazard_if.slave hz
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] opcode;
    logic       rs1_used;
    logic       rs2_used;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;
    logic       mem_stall;

    logic pc_stall;
    logic if_id_stall;
    logic id_ex_bubble;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_stall;

    assign rs1    = hz.id_instr[19:15];
    assign rs2    = hz.id_instr[24:20];
    assign opcode = hz.id_instr[6:0];

    // Source-operand usage by opcode; register fields of formats that have
    // no such operand carry immediate bits and must not create false hazards.
    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL:     rs1_used = 1'b0;
            default:                      rs1_used = 1'b1;
        endcase
        case (opcode)
            OP_REG, OP_STORE, OP_BRANCH:  rs2_used = 1'b1;
            default:                      rs2_used = 1'b0;
        endcase
    end

    assign rs1_hit   = rs1_used && (rs1 == hz.ex_rd);
    assign rs2_hit   = rs2_used && (rs2 == hz.ex_rd);
    assign load_use  = hz.ex_mem_read && (hz.ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    assign mem_stall = hz.dmem_req && !hz.dmem_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter the wait on a stalled access, leave as soon as the
    // access completes or is withdrawn.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_ready || !hz.dmem_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Pipeline controls, highest priority first: reset, memory stall,
    // taken branch, load-use. A branch seen during a memory stall is not
    // lost: EX is frozen, so branch_taken stays high and the flush lands in
    // the first released cycle. Likewise a load-use hazard is re-evaluated
    // once the memory stall clears.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_stall = 1'b1;
            end else if (hz.branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // Wait counter, sticky timeout flag and saturating performance counters.
    // The timeout compares the registered count, so it sets one edge after
    // the count reaches the limit.
    always_comb begin
        wait_cnt_d     = wait_cnt_q;
        mem_timeout_d  = mem_timeout_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;

        if (state_q == ST_RUN) begin
            wait_cnt_d = 16'd0;
        end else if (mem_stall && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end

        if (wait_cnt_q >= TIMEOUT_LIM) begin
            mem_timeout_d = 1'b1;
        end

        if ((pc_stall || ex_mem_stall) && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end

        if (if_id_flush && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    // Counter and flag registers; reset aborts any wait without counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q     <= 16'd0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign hz.pc_stall     = pc_stall;
    assign hz.if_id_stall  = if_id_stall;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_stall = ex_mem_stall;
    assign hz.mem_wb_stall = mem_wb_stall;
    assign hz.mem_timeout  = mem_timeout_q;
    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle comparison against a behavioural model
// plus directed scenarios with hand-computed expectations.
module tb_hazard_ctrl;

    localparam int T = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    hazard_if hz ();

    hazard_ctrl #(.TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected control vector {pc, if_id_stall, bubble, if_id_flush,
    // id_ex_flush, ex_mem_stall, mem_wb_stall} from the priority rules.
    function automatic logic [6:0] exp_ctrl(input logic rst, input logic [31:0] instr,
                                            input logic [4:0] rd, input logic mr,
                                            input logic br, input logic req, input logic rdy);
        int op, r1, r2;
        bit u1, u2, lu;
        op = int'(instr[6:0]);
        r1 = int'(instr[19:15]);
        r2 = int'(instr[24:20]);
        u1 = !(op == 'h37 || op == 'h17 || op == 'h6F);
        u2 = (op == 'h33 || op == 'h23 || op == 'h63);
        lu = mr && rd != 0 && ((u1 && r1 == int'(rd)) || (u2 && r2 == int'(rd)));
        if (rst)              return 7'b0000000;
        if (req && !rdy)      return 7'b1100011;
        if (br)               return 7'b0001100;
        if (lu)               return 7'b1110000;
        return 7'b0000000;
    endfunction

    int m_stall = 0;
    int m_flush = 0;
    int m_run = 0;
    bit m_to = 0;
    bit m_valid = 0;

    logic [6:0] dut_ctrl;
    assign dut_ctrl = {hz.pc_stall, hz.if_id_stall, hz.id_ex_bubble, hz.if_id_flush,
                       hz.id_ex_flush, hz.ex_mem_stall, hz.mem_wb_stall};

    // Model update. m_run is the length of the unbroken memory-stall run
    // ending just before this cycle; the wait count visible in this cycle
    // is one less than that, and the flag sets once it has reached T.
    always @(posedge clk) begin
        logic [6:0] e;
        e = exp_ctrl(reset, hz.id_instr, hz.ex_rd, hz.ex_mem_read,
                     hz.branch_taken, hz.dmem_req, hz.dmem_ready);
        if (reset) begin
            m_stall = 0;
            m_flush = 0;
            m_run   = 0;
            m_to    = 0;
            m_valid = 1;
        end else begin
            if ((e[6] || e[1]) && m_stall < 65535) m_stall++;
            if (e[3] && m_flush < 65535) m_flush++;
            if (m_run > T) m_to = 1;
            m_run = (hz.dmem_req && !hz.dmem_ready) ? m_run + 1 : 0;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ctrl_outs", 32'(dut_ctrl),
                32'(exp_ctrl(reset, hz.id_instr, hz.ex_rd, hz.ex_mem_read,
                             hz.branch_taken, hz.dmem_req, hz.dmem_ready)));
            chk("stall_cycles", 32'(hz.stall_cycles), m_stall);
            chk("flush_count", 32'(hz.flush_count), m_flush);
            chk("mem_timeout", 32'(hz.mem_timeout), 32'(m_to));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_instr     = 32'h00000013;
        hz.ex_rd        = 5'd0;
        hz.ex_mem_read  = 1'b0;
        hz.branch_taken = 1'b0;
        hz.dmem_req     = 1'b0;
        hz.dmem_ready   = 1'b0;
    endtask

    task automatic load_use_inputs();
        hz.ex_mem_read = 1'b1;
        hz.ex_rd       = 5'd5;
        hz.id_instr    = 32'h00528333;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        #1;
        chk("reset_stall_cycles", 32'(hz.stall_cycles), 0);
        chk("reset_timeout", 32'(hz.mem_timeout), 0);

        // Load-use on add x6,x5,x5 behind a load to x5.
        load_use_inputs();
        #1;
        chk("lu_pc_stall", 32'(hz.pc_stall), 1);
        chk("lu_if_id_stall", 32'(hz.if_id_stall), 1);
        chk("lu_bubble", 32'(hz.id_ex_bubble), 1);
        chk("lu_ex_mem_stall", 32'(hz.ex_mem_stall), 0);
        step(1);
        idle();
        #1;
        chk("lu_released", 32'(hz.pc_stall), 0);
        chk("lu_stall_cycles", 32'(hz.stall_cycles), 1);

        // Load to x0 never interlocks.
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_instr = 32'h00000093;
        #1;
        chk("x0_no_stall", 32'(hz.pc_stall), 0);
        step(1);

        // addi x5,x0,5: rs2 field equals 5 but addi has no rs2.
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_instr = 32'h00500293;
        #1;
        chk("addi_rs2_unused", 32'(hz.pc_stall), 0);
        step(1);

        // lui x6 with rs1 field 5: no rs1.
        hz.id_instr = 32'h00028337;
        #1;
        chk("lui_rs1_unused", 32'(hz.pc_stall), 0);
        step(1);

        // sw x5,0(x6): store uses rs2.
        hz.id_instr = 32'h00532023;
        #1;
        chk("store_rs2_used", 32'(hz.id_ex_bubble), 1);
        step(1);
        idle();
        #1;
        chk("store_stall_cycles", 32'(hz.stall_cycles), 2);

        // Taken branch outranks load-use.
        load_use_inputs();
        hz.branch_taken = 1'b1;
        #1;
        chk("br_if_id_flush", 32'(hz.if_id_flush), 1);
        chk("br_id_ex_flush", 32'(hz.id_ex_flush), 1);
        chk("br_no_bubble", 32'(hz.id_ex_bubble), 0);
        step(1);
        idle();
        #1;
        chk("br_flush_count", 32'(hz.flush_count), 1);
        chk("br_flush_one_cycle", 32'(hz.if_id_flush), 0);

        // Three-cycle memory wait.
        pulse_reset();
        hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
        #1;
        chk("mw_all_stalls", 32'(dut_ctrl), 32'h63);
        step(3);
        hz.dmem_ready = 1'b1;
        #1;
        chk("mw_released", 32'(dut_ctrl), 0);
        step(1);
        idle();
        #1;
        chk("mw_stall_cycles", 32'(hz.stall_cycles), 3);
        chk("mw_no_timeout", 32'(hz.mem_timeout), 0);

        // Load-use during a memory stall waits for the release.
        load_use_inputs();
        hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
        #1;
        chk("mslu_no_bubble", 32'(hz.id_ex_bubble), 0);
        chk("mslu_mem_stall", 32'(hz.mem_wb_stall), 1);
        step(1);
        hz.dmem_ready = 1'b1;
        #1;
        chk("mslu_bubble_after", 32'(hz.id_ex_bubble), 1);
        chk("mslu_ex_mem_free", 32'(hz.ex_mem_stall), 0);
        step(1);
        idle();
        #1;
        chk("mslu_stall_cycles", 32'(hz.stall_cycles), 5);

        // Branch held through a two-cycle memory stall.
        pulse_reset();
        hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0; hz.branch_taken = 1'b1;
        #1;
        chk("bw_no_flush", 32'(hz.if_id_flush), 0);
        step(2);
        hz.dmem_ready = 1'b1;
        #1;
        chk("bw_if_id_flush", 32'(hz.if_id_flush), 1);
        chk("bw_id_ex_flush", 32'(hz.id_ex_flush), 1);
        chk("bw_pc_free", 32'(hz.pc_stall), 0);
        step(1);
        idle();
        #1;
        chk("bw_flush_count", 32'(hz.flush_count), 1);
        chk("bw_stall_cycles", 32'(hz.stall_cycles), 2);

        // Timeout with limit 4.
        pulse_reset();
        hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
        step(5);
        chk("to_not_yet", 32'(hz.mem_timeout), 0);
        step(1);
        chk("to_set", 32'(hz.mem_timeout), 1);
        hz.dmem_ready = 1'b1;
        step(1);
        idle();
        step(2);
        chk("to_sticky", 32'(hz.mem_timeout), 1);
        pulse_reset();
        #1;
        chk("to_cleared", 32'(hz.mem_timeout), 0);

        // Reset in the middle of a wait.
        load_use_inputs();
        hz.branch_taken = 1'b1;
        hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
        step(2);
        chk("rw_pre_stalls", 32'(hz.stall_cycles), 2);
        reset = 1'b1;
        #1;
        chk("rw_outputs_zero", 32'(dut_ctrl), 0);
        step(1);
        reset = 1'b0;
        idle();
        #1;
        chk("rw_stall_cycles", 32'(hz.stall_cycles), 0);
        chk("rw_flush_count", 32'(hz.flush_count), 0);
        chk("rw_timeout", 32'(hz.mem_timeout), 0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
